pool_window_gen: RTL
====================

Name: pool_window_gen

Overview:
- Producer side of the 2x2 max-pooling stage.
- Accepts one raster-order stream of 16-bit sign-magnitude feature-map pixels (bit 15 = sign, [14:0] = magnitude) from the convolution engine.
- Buffers one row and emits each non-overlapping 2x2 window as four parallel words plus a one-cycle strobe; this drives the max unit's enable and its A/B/C/D inputs directly.
- One instance per feature-map channel.

Parameters:
IMG_W, 24, feature-map width in pixels; even, >= 2
IMG_H, 24, feature-map height in pixels; even, >= 2
DATA_W, 16, pixel width; sign-magnitude, MSB = sign

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous to clk, active-high
in_sof  input  1  start of frame; forces the position counters to pixel (0,0)
in_valid  input  1  in_data carries a pixel this cycle
in_data  input  DATA_W  pixel, raster order (row-major, left to right)
win_valid  output  1  one-cycle strobe: A/B/C/D hold a new window
A  output  DATA_W  top-left pixel of window
B  output  DATA_W  top-right pixel
C  output  DATA_W  bottom-left pixel
D  output  DATA_W  bottom-right pixel
win_last  output  1  asserted with win_valid on the final window of a frame

Behaviour:
- State
  - col counter: 0..IMG_W-1
  - row counter: 0..IMG_H-1
  - line buffer: IMG_W x DATA_W
  - c_hold register: DATA_W
- Counter advance
  - Counters advance only on beats with in_valid=1; idle cycles (in_valid=0) change nothing.
  - col wraps IMG_W-1 -> 0 and increments row.
  - row wraps IMG_H-1 -> 0, so frames may be back-to-back with no gap.
- Even row (row[0]=0): each pixel is written to line buffer[col]. No output.
- Odd row, even col: the pixel is stored in c_hold.
- Odd row, odd col: the window is registered on the next clock edge:
  - A <= buf[col-1]
  - B <= buf[col]
  - C <= c_hold
  - D <= in_data
  - win_valid <= 1
  - win_last <= 1 only if row=IMG_H-1 and col=IMG_W-1
- Latency: win_valid rises exactly 1 cycle after the beat carrying the D pixel.
  - Windows are emitted in raster order of window position.
  - There are (IMG_W/2)*(IMG_H/2) windows per frame.
- Output hold
  - win_valid and win_last are high for exactly one cycle per window, otherwise 0.
  - A-D keep their last values when win_valid=0.
- Data transparency: pixels pass bit-exact, with no sign or magnitude manipulation. 0x8000 (negative zero) is passed unchanged.
- No backpressure: the downstream max unit accepts every strobe. Maximum rate is one window per 2 input beats.
- in_sof
  - in_sof=1 with in_valid=1: counters reset and this beat is treated as pixel (0,0).
  - in_sof=1 with in_valid=0: counters reset to (0,0); nothing is written.
  - A partial window in progress is abandoned, with no strobe.
  - in_sof has no effect on a strobe already registered in that cycle.
- Reset
  - rst=1 has priority over everything else.
  - On reset: counters=0, win_valid=0, win_last=0, A=B=C=D=0, c_hold=0.
  - Line buffer is not cleared; it is always rewritten by the even row before being read.
  - Reset mid-frame discards the partial frame. The next valid beat after reset is pixel (0,0).
- Widths: col is $clog2(IMG_W) bits and row is $clog2(IMG_H) bits. The counters wrap by comparison against IMG_W-1 and IMG_H-1, not by natural overflow.

Decomposition:
- Shared package (pool_pkg):
  - DATA_W = 16 and SIGN_BIT = 15
  - pixel typedef (logic [DATA_W-1:0])
  - default LeNet map sizes (24 for C1, 8 for C3)
- One sub-module, pool_line_buf:
  - IMG_W x DATA_W register array
  - one synchronous write port (we, waddr, wdata)
  - two combinational read ports (raddr0/rdata0, raddr1/rdata1), supplying A and B in the same cycle

Test Plan:
- IMG_W=4, IMG_H=4, pixels 0..15 with continuous in_valid -> four strobes:
  - (A,B,C,D) = (0,1,4,5), (2,3,6,7), (8,9,12,13), (10,11,14,15)
  - each strobe one cycle after pixels 5, 7, 13, 15
  - win_last only on the 4th
- Same frame with in_valid=0 inserted on random cycles (50%) -> identical window values and order; each strobe is 1 cycle after its D beat.
- Two back-to-back frames (pixels 0..15, then 100..115) -> 8 windows; second-frame first window = (100,101,104,105); win_last on windows 4 and 8.
- Sign-magnitude passthrough: pixels 0x8005, 0x0003, 0x8000, 0x7FFF as the first 2x2 block (IMG_W=2, IMG_H=2) -> A=0x8005, B=0x0003, C=0x8000, D=0x7FFF, win_last=1.
- rst=1 after pixel 6 of a 4x4 frame, then pixels 0..15 -> all outputs 0 during reset; exactly four correct windows afterwards, with no stale strobe.
- in_sof=1 with in_valid on pixel 9 of a frame, then 15 further pixels (0..15 counting from the sof beat) -> the partial window is discarded and four windows are emitted per the first scenario.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2 max-pooling front end: pixel format and
// the LeNet feature-map sizes the pooling stages are normally built for.
package pool_pkg;

  localparam int DATA_W   = 16;
  localparam int SIGN_BIT = 15;

  typedef logic [DATA_W-1:0] pixel_t;

  localparam int LENET_C1_W = 24;
  localparam int LENET_C1_H = 24;
  localparam int LENET_C3_W = 8;
  localparam int LENET_C3_H = 8;

endpackage

// File: rtl/pool_line_buf.sv
// One-row pixel store: a single synchronous write port and two combinational
// read ports so both top-row pixels of a window are available together.
module pool_line_buf #(
  parameter int DEPTH  = 24,
  parameter int DATA_W = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr0,
  output logic [DATA_W-1:0] rdata0,
  input  logic [AW-1:0]     raddr1,
  output logic [DATA_W-1:0] rdata1
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/pool_window_gen.sv
// Raster-to-window converter: buffers even rows and emits each
// non-overlapping 2x2 window as A/B/C/D with a one-cycle strobe.
module pool_window_gen #(
  parameter int IMG_W  = pool_pkg::LENET_C1_W,
  parameter int IMG_H  = pool_pkg::LENET_C1_H,
  parameter int DATA_W = pool_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_sof,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              win_valid,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] C,
  output logic [DATA_W-1:0] D,
  output logic              win_last
);

  import pool_pkg::*;

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]     col, col_eff;
  logic [RW-1:0]     row, row_eff;
  logic [DATA_W-1:0] c_hold;
  logic [DATA_W-1:0] buf_a, buf_b;
  logic              buf_we;
  logic              col_last, row_last;

  // in_sof overrides the stored position so the same beat lands on (0,0).
  assign col_eff  = in_sof ? '0 : col;
  assign row_eff  = in_sof ? '0 : row;
  assign col_last = (col_eff == CW'(IMG_W - 1));
  assign row_last = (row_eff == RW'(IMG_H - 1));
  assign buf_we   = in_valid && !rst && !row_eff[0];

  pool_line_buf #(
    .DEPTH  (IMG_W),
    .DATA_W (DATA_W),
    .AW     (CW)
  ) u_line_buf (
    .clk    (clk),
    .we     (buf_we),
    .waddr  (col_eff),
    .wdata  (in_data),
    .raddr0 (col_eff - CW'(1)),
    .rdata0 (buf_a),
    .raddr1 (col_eff),
    .rdata1 (buf_b)
  );

  // Window register stage: strobe and A-D settle one cycle after the D beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      c_hold    <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      A         <= '0;
      B         <= '0;
      C         <= '0;
      D         <= '0;
    end else begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      if (in_valid) begin
        if (row_eff[0] && col_eff[0]) begin
          A         <= buf_a;
          B         <= buf_b;
          C         <= c_hold;
          D         <= in_data;
          win_valid <= 1'b1;
          win_last  <= row_last && col_last;
        end else if (row_eff[0]) begin
          c_hold <= in_data;
        end
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row_eff + RW'(1);
        end else begin
          col <= col_eff + CW'(1);
          row <= row_eff;
        end
      end else if (in_sof) begin
        col <= '0;
        row <= '0;
      end
    end
  end

endmodule
